// File: rtl/qctrl_pkg.sv
// Shared types and constants for the quantum issue controller.
// Holds the opcode and funct3 encodings, the FSM state type and the queued-op record.
package qctrl_pkg;

  localparam logic [6:0] OPCODE_QUANTUM = 7'b0001011;
  localparam logic [2:0] QF3_MEASURE    = 3'b010;

  // Immediate width carried in a queued op; the top-level XLEN must match it.
  localparam int QIMM_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  typedef struct packed {
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [QIMM_W-1:0] imm;
  } qop_t;

  function automatic logic is_measure(input qop_t op);
    return op.funct3 == QF3_MEASURE;
  endfunction

endpackage

// File: rtl/qop_fifo.sv
// Synchronous FIFO of queued quantum ops with show-ahead head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module qop_fifo
  import qctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  qop_t i_push_data,
  input  logic i_pop,
  output qop_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  qop_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/quantum_issue_ctrl.sv
// Decode-stage sequencer: queues quantum ops, issues them one at a time and
// writes measurement results back, stalling decode on pending destination registers.
//
// state | meaning
// IDLE  | no op in flight; pops the FIFO head when one is queued
// ISSUE | op offered to the quantum unit (q_valid), held until q_ready
// WAIT  | op accepted by the unit, waiting for q_done
// WB    | measurement result offered to the register file (wb_valid)
module quantum_issue_ctrl
  import qctrl_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int XLEN   = QIMM_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] imm,
  output logic            q_valid,
  input  logic            q_ready,
  output logic [2:0]      q_funct3,
  output logic [6:0]      q_funct7,
  output logic [4:0]      q_rs1,
  output logic [4:0]      q_rs2,
  output logic [XLEN-1:0] q_imm,
  input  logic            q_done,
  input  logic [XLEN-1:0] q_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            hazard,
  output logic            busy
);

  state_t          r_state;
  qop_t            r_iss;
  logic            r_q_valid;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic [31:0]     r_pending;

  logic        w_is_q;
  logic        w_is_meas;
  logic        w_hit_rs1;
  logic        w_hit_rs2;
  logic        w_hit_rd;
  logic        w_hazard;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_wb_fire;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  qop_t        w_push_op;
  qop_t        w_head;

  assign w_is_q    = (opcode == OPCODE_QUANTUM);
  assign w_is_meas = w_is_q && (funct3 == QF3_MEASURE);

  // x0 never holds a pending result, so a zero field can never stall.
  assign w_hit_rs1 = (rs1 != 5'd0) && r_pending[rs1];
  assign w_hit_rs2 = (rs2 != 5'd0) && r_pending[rs2];
  assign w_hit_rd  = (rd  != 5'd0) && r_pending[rd];
  assign w_hazard  = in_valid && (w_hit_rs1 || w_hit_rs2 || w_hit_rd);

  assign in_ready  = !w_hazard && (!w_is_q || !w_full);
  assign w_push    = in_valid && in_ready && w_is_q;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_wb_fire = (r_state == WB) && wb_ready;

  always_comb begin
    w_push_op        = '0;
    w_push_op.funct3 = funct3;
    w_push_op.funct7 = funct7;
    w_push_op.rd     = rd;
    w_push_op.rs1    = rs1;
    w_push_op.rs2    = rs2;
    w_push_op.imm    = QIMM_W'(imm);
  end

  qop_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_op),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_iss      <= '0;
      r_q_valid  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_iss     <= w_head;
            r_q_valid <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (q_ready) begin
            r_q_valid <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (q_done) begin
            if (is_measure(r_iss) && (r_iss.rd != 5'd0)) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_iss.rd;
              r_wb_data  <= q_result;
              r_state    <= WB;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Set and clear never collide: a pending rd blocks any new op naming it.
  assign w_set_mask = (w_push && w_is_meas && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
  assign w_clr_mask = w_wb_fire ? (32'd1 << r_wb_rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign q_valid  = r_q_valid;
  assign q_funct3 = r_iss.funct3;
  assign q_funct7 = r_iss.funct7;
  assign q_rs1    = r_iss.rs1;
  assign q_rs2    = r_iss.rs2;
  assign q_imm    = XLEN'(r_iss.imm);
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign hazard   = w_hazard;
  assign busy     = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_quantum_issue_ctrl.sv
// Bench for quantum_issue_ctrl: directed scenarios then random traffic, every
// cycle compared against a transaction-level model (op queue, pending set, slot phase).
module tb_quantum_issue_ctrl;
  import qctrl_pkg::*;

  localparam int QDEPTH = 4;
  localparam int XLEN   = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm;
  logic            q_valid, q_ready;
  logic [2:0]      q_funct3;
  logic [6:0]      q_funct7;
  logic [4:0]      q_rs1, q_rs2;
  logic [XLEN-1:0] q_imm;
  logic            q_done;
  logic [XLEN-1:0] q_result;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            hazard, busy;

  always #5 clk = ~clk;

  quantum_issue_ctrl #(.QDEPTH(QDEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .q_valid(q_valid), .q_ready(q_ready), .q_funct3(q_funct3),
    .q_funct7(q_funct7), .q_rs1(q_rs1), .q_rs2(q_rs2), .q_imm(q_imm),
    .q_done(q_done), .q_result(q_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .hazard(hazard), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ops waiting in order, one op held by the issue slot,
  // and the slot's phase (free / offered / executing / writing back).
  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } mop_t;

  localparam int S_FREE = 0, S_OFFER = 1, S_EXEC = 2, S_WBK = 3;

  mop_t        m_q[$];
  mop_t        m_cur;
  int          m_slot = S_FREE;
  bit [31:0]   m_pend = '0;
  logic [31:0] m_wbdata = '0;
  bit          m_just_reset = 1'b0;

  int          done_cnt = 0;
  int          done_lat = 0;
  bit          res_rand = 1'b1;
  logic [31:0] res_fix = '0;
  bit          clr_done_on_rst = 1'b1;

  function automatic bit pend_hit(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  task automatic step();
    bit e_isq, e_haz, e_rdy, e_qv, e_wbv, e_busy, acc;
    mop_t op;
    q_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      q_done = (done_cnt == 0);
    end
    q_result = (q_done && !res_rand) ? res_fix : $urandom;
    @(negedge clk);
    e_isq  = (opcode == OPCODE_QUANTUM);
    e_haz  = in_valid && (pend_hit(rs1) || pend_hit(rs2) || pend_hit(rd));
    e_rdy  = !e_haz && (!e_isq || (m_q.size() < QDEPTH));
    e_qv   = (m_slot == S_OFFER);
    e_wbv  = (m_slot == S_WBK);
    e_busy = (m_q.size() != 0) || (m_slot != S_FREE);
    check_val("in_ready", in_ready, e_rdy);
    check_val("hazard", hazard, e_haz);
    check_val("q_valid", q_valid, e_qv);
    check_val("wb_valid", wb_valid, e_wbv);
    check_val("busy", busy, e_busy);
    if (e_qv)
      check_val("q_op", {q_funct3, q_funct7, q_rs1, q_rs2, q_imm},
                {m_cur.f3, m_cur.f7, m_cur.rs1, m_cur.rs2, m_cur.imm});
    if (e_wbv)
      check_val("wb_op", {wb_rd, wb_data}, {m_cur.rd, m_wbdata});
    if (m_just_reset)
      check_val("rst_data", {q_funct3, q_funct7, q_rs1, q_rs2, q_imm, wb_rd, wb_data}, '0);
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_pend = '0;
      m_slot = S_FREE;
      m_just_reset = 1'b1;
      if (clr_done_on_rst) done_cnt = 0;
    end else begin
      m_just_reset = 1'b0;
      acc = in_valid && e_rdy && e_isq;
      case (m_slot)
        S_FREE:  if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_slot = S_OFFER; end
        S_OFFER: if (q_ready) begin
                   m_slot = S_EXEC;
                   done_cnt = (done_lat > 0) ? done_lat : int'($urandom_range(1, 4));
                 end
        S_EXEC:  if (q_done) begin
                   if (m_cur.f3 == QF3_MEASURE && m_cur.rd != 5'd0) begin
                     m_wbdata = q_result;
                     m_slot = S_WBK;
                   end else m_slot = S_FREE;
                 end
        default: if (wb_ready) begin m_pend[m_cur.rd] = 1'b0; m_slot = S_FREE; end
      endcase
      if (acc) begin
        op.f3 = funct3; op.f7 = funct7; op.rd = rd; op.rs1 = rs1; op.rs2 = rs2; op.imm = imm;
        m_q.push_back(op);
        if (funct3 == QF3_MEASURE && rd != 5'd0) m_pend[rd] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    in_valid = v; opcode = op; funct3 = f3; funct7 = 7'($urandom);
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic idle_in();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic rand_instr();
    logic [6:0] op;
    logic [2:0] f3;
    int sel = $urandom_range(0, 9);
    op = (sel < 5) ? OPCODE_QUANTUM : (sel < 8) ? OP_ADD : 7'($urandom);
    f3 = ($urandom_range(0, 9) < 4) ? QF3_MEASURE : 3'($urandom);
    drive(($urandom_range(0, 3) != 0), op, f3, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    rst_n = 1'b0; q_ready = 1'b0; wb_ready = 1'b0; q_done = 1'b0; q_result = '0;
    idle_in();
    #1;
    run(2);
    rst_n = 1'b1;
    run(2);

    // Single non-measure op, immediate 5, done three cycles after accept.
    q_ready = 1'b1; done_lat = 3;
    drive(1'b1, OPCODE_QUANTUM, 3'b000, 5'd4, 5'd1, 5'd2, 32'd5);
    step();
    idle_in();
    run(8);

    // Measurement to x7; an ADD reading x7 stalls until writeback retires.
    res_rand = 1'b0; res_fix = 32'h1; wb_ready = 1'b1; done_lat = 2;
    drive(1'b1, OPCODE_QUANTUM, QF3_MEASURE, 5'd7, 5'd0, 5'd0, 32'h33);
    step();
    drive(1'b1, OP_ADD, 3'b000, 5'd1, 5'd7, 5'd2, 32'd0);
    run(12);
    idle_in();
    run(2);

    // Six pushes against a stalled unit: the sixth must be refused.
    q_ready = 1'b0; done_lat = 1; res_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OPCODE_QUANTUM, 3'b001, 5'd0, 5'd0, 5'd0, 32'(100 + i));
      step();
    end
    idle_in();
    run(3);
    q_ready = 1'b1;
    run(30);

    // Measurement into x0 produces no writeback.
    drive(1'b1, OPCODE_QUANTUM, QF3_MEASURE, 5'd0, 5'd3, 5'd0, 32'h77);
    step();
    idle_in();
    run(8);

    // Reset while the first of three ops executes; its late q_done is stale.
    done_lat = 20; clr_done_on_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OPCODE_QUANTUM, 3'b100, 5'd0, 5'd0, 5'd0, 32'(200 + i));
      step();
    end
    idle_in();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, OP_ADD, 3'b000, 5'd1, 5'd7, 5'd7, 32'd0);
    step();
    idle_in();
    run(25);
    clr_done_on_rst = 1'b1;

    // Writeback back-pressure: result must stay put and nothing new issues.
    done_lat = 1; res_rand = 1'b0; res_fix = 32'hABCD; wb_ready = 1'b0;
    drive(1'b1, OPCODE_QUANTUM, QF3_MEASURE, 5'd3, 5'd0, 5'd0, 32'h10);
    step();
    drive(1'b1, OPCODE_QUANTUM, 3'b000, 5'd0, 5'd0, 5'd0, 32'h11);
    step();
    idle_in();
    run(10);
    wb_ready = 1'b1;
    run(10);

    // Random traffic with occasional resets.
    done_lat = 0; res_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rand_instr();
      q_ready  = ($urandom_range(0, 2) != 0);
      wb_ready = ($urandom_range(0, 1) != 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    idle_in();
    q_ready = 1'b1; wb_ready = 1'b1;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
